cnn_window_sched: RTL and testbench
===================================

CNN_WINDOW_SCHED -- requirements
Module: cnn_window_sched

Interface
- REQ-001 SHALL have parameter IMG_W, default 28, image width and height in pixels.
- REQ-002 SHALL have parameter WIN, default 5, window edge in pixels.
- REQ-003 SHALL have parameter STRIDE, default 1, window step in pixels.
- REQ-004 SHALL have parameter TIMEOUT_CYC, default 4096, DONE wait limit in cycles.
- REQ-005 SHALL have port CLK, input, 1, the single clock; all logic on its rising edge.
- REQ-006 SHALL have port RST, input, 1, synchronous active-high reset.
- REQ-007 SHALL have port FRAME_START, input, 1, one-cycle request to scan one stored image.
- REQ-008 SHALL have port PIX_ADDR, output, 10, pixel memory address; pixel index is row*IMG_W+col.
- REQ-009 SHALL have port PIX_RDATA, input, 8, pixel data, valid one cycle after PIX_ADDR.
- REQ-010 SHALL have port CNN_START, output, 1, one-cycle start pulse to simpleCNN.
- REQ-011 SHALL have ports CNN_X and CNN_Y, output, 5 each, window row and column origin.
- REQ-012 SHALL have port CNN_IMGIN, output, 200, packed 5x5 window.
- REQ-013 SHALL have port CNN_DONE, input, 1, simpleCNN completion.
- REQ-014 SHALL have port CNN_OUT, input, 4, simpleCNN class result.
- REQ-015 SHALL have port RES_VALID, output, 1, one-cycle result strobe.
- REQ-016 SHALL have port RES_CLASS, output, 4, captured CNN_OUT.
- REQ-017 SHALL have ports RES_X and RES_Y, output, 5 each, origin of the window that produced the result.
- REQ-018 SHALL have port BUSY, output, 1, high whenever the state is not IDLE.
- REQ-019 SHALL have port FRAME_DONE, output, 1, one-cycle pulse after the last window.

Function
- REQ-020 SHALL use FSM states IDLE, FETCH, ISSUE, WAIT, NEXT.
- REQ-021 SHALL go IDLE->FETCH on FRAME_START, with X=Y=0; FRAME_START outside IDLE is ignored.
- REQ-022 SHALL, in FETCH, issue 25 addresses on consecutive cycles, order r=0..4 outer, c=0..4 inner, PIX_ADDR=(X+r)*IMG_W+(Y+c).
- REQ-023 SHALL write each returned byte to CNN_IMGIN[(r*5+c)*8 +: 8] one cycle after its address, so FETCH lasts 26 cycles.
- REQ-024 SHALL, in ISSUE, assert CNN_START for exactly one cycle with CNN_X/CNN_Y/CNN_IMGIN already stable, then go to WAIT.
- REQ-025 SHALL hold CNN_X, CNN_Y and CNN_IMGIN constant from ISSUE until DONE is accepted.
- REQ-026 SHALL, in WAIT, accept the first CNN_DONE=1 cycle: latch CNN_OUT, pulse RES_VALID with RES_X/RES_Y in the next cycle, go to NEXT.
- REQ-027 SHALL ignore CNN_DONE in every state other than WAIT.
- REQ-028 SHALL, in NEXT, advance Y by STRIDE; when Y+STRIDE>IMG_W-WIN, set Y=0 and advance X by STRIDE.
- REQ-029 SHALL, when X also passes IMG_W-WIN, pulse FRAME_DONE and return to IDLE; otherwise go to FETCH.
- REQ-030 SHALL, with default parameters, scan 24x24=576 windows per frame, last origin (23,23).
- REQ-031 SHALL compute addresses at 10 bits with no truncation for IMG_W<=32.

Reset
- REQ-032 SHALL, on RST, force IDLE and clear X, Y, CNN_START, RES_VALID, FRAME_DONE, BUSY, PIX_ADDR, RES_CLASS, RES_X, RES_Y and CNN_IMGIN to 0.
- REQ-033 SHALL, on RST mid-frame, abandon the frame with no RES_VALID or FRAME_DONE; the first cycle after reset is IDLE.

Configuration
- REQ-034 SHALL compile a DONE watchdog only when CNN_SCHED_TIMEOUT_EN is defined.
- REQ-035 SHALL, with the macro defined, count WAIT cycles; at TIMEOUT_CYC without DONE, pulse FRAME_DONE, skip RES_VALID and return to IDLE.
- REQ-036 SHALL, with the macro undefined, wait in WAIT indefinitely with no counter logic.

Structure
- REQ-037 SHALL place the state enum, IMG_W/WIN defaults and the window byte-offset function in package cnn_sched_pkg.
- REQ-038 SHALL implement fetch-and-pack as sub-module cnn_win_fetch (start/addr/rdata/done/200-bit window); the FSM stays in the top.

Verification
- REQ-039 SHALL cover: FRAME_START with pixel memory value = index mod 256 -> first CNN_IMGIN byte 0 is 0x00, byte 24 is 0x74 (pixel 116), CNN_START 27 cycles after FRAME_START.
- REQ-040 SHALL cover: DONE model returning (X+Y) mod 16 after 10 cycles -> 576 RES_VALIDs, last one with RES_X=RES_Y=23 and RES_CLASS=14, then one FRAME_DONE.
- REQ-041 SHALL cover: STRIDE=4 -> 36 windows, origins 0,4,...,20.
- REQ-042 SHALL cover: CNN_DONE pulses during FETCH, and FRAME_START while BUSY -> no extra RES_VALID and no restart.
- REQ-043 SHALL cover: RST asserted in WAIT of window 5 -> IDLE next cycle, all outputs 0, and a new frame starts again at (0,0).
- REQ-044 SHALL cover: with CNN_SCHED_TIMEOUT_EN, TIMEOUT_CYC=64 and DONE never asserted -> FRAME_DONE 64 cycles after CNN_START and no RES_VALID.

Source files
------------

// File: rtl/cnn_sched_pkg.sv
// Shared types and helpers for the CNN window scheduler: FSM state encoding,
// default image/window geometry and the window byte-offset function.
package cnn_sched_pkg;

    localparam int IMG_W_DEF = 28;
    localparam int WIN_DEF   = 5;
    localparam int PIX_W     = 8;
    localparam int WIN_BITS  = WIN_DEF * WIN_DEF * PIX_W;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT,
        NEXT
    } sched_state_e;

    // Bit offset of pixel (r, c) inside the packed window.
    function automatic logic [7:0] win_byte_off(input logic [2:0] r, input logic [2:0] c);
        return 8'((32'(r) * WIN_DEF + 32'(c)) * PIX_W);
    endfunction

endpackage

// File: rtl/cnn_win_fetch.sv
// Walks a 5x5 window of the pixel memory one address per cycle and packs the
// returned bytes; done_o is high in the cycle the last byte arrives.
module cnn_win_fetch
    import cnn_sched_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [4:0]          x_i,
    input  logic [4:0]          y_i,
    output logic [9:0]          addr_o,
    input  logic [7:0]          rdata_i,
    output logic                done_o,
    output logic [WIN_BITS-1:0] win_o
);

    localparam logic [2:0] LAST = 3'(WIN_DEF - 1);

    logic                issue_q, issue_d;
    logic [2:0]          r_q, r_d, c_q, c_d;
    logic [9:0]          addr_q, addr_d;
    logic                pend_q, pend_d;
    logic                pend_last_q, pend_last_d;
    logic [7:0]          pend_off_q, pend_off_d;
    logic [WIN_BITS-1:0] win_q, win_d;

    always_comb begin
        issue_d     = issue_q;
        r_d         = r_q;
        c_d         = c_q;
        addr_d      = addr_q;
        pend_d      = issue_q;
        pend_off_d  = win_byte_off(r_q, c_q);
        pend_last_d = issue_q && (r_q == LAST) && (c_q == LAST);
        win_d       = win_q;
        // Memory returns data one cycle after the address, so writes trail issues.
        if (pend_q) begin
            win_d[pend_off_q +: 8] = rdata_i;
        end
        if (start_i) begin
            issue_d = 1'b1;
            r_d     = '0;
            c_d     = '0;
            addr_d  = 10'(x_i) * 10'(IMG_W) + 10'(y_i);
        end else if (issue_q) begin
            if (c_q == LAST) begin
                c_d = '0;
                if (r_q == LAST) begin
                    issue_d = 1'b0;
                end else begin
                    r_d    = r_q + 3'd1;
                    addr_d = addr_q + 10'(IMG_W - WIN_DEF + 1);
                end
            end else begin
                c_d    = c_q + 3'd1;
                addr_d = addr_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            issue_q     <= 1'b0;
            r_q         <= '0;
            c_q         <= '0;
            addr_q      <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            pend_off_q  <= '0;
            win_q       <= '0;
        end else begin
            issue_q     <= issue_d;
            r_q         <= r_d;
            c_q         <= c_d;
            addr_q      <= addr_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            pend_off_q  <= pend_off_d;
            win_q       <= win_d;
        end
    end

    assign addr_o = addr_q;
    assign done_o = pend_q && pend_last_q;
    assign win_o  = win_q;

endmodule

// File: rtl/cnn_window_sched.sv
// Scans every window origin of a stored image, hands each packed window to
// simpleCNN and reports its class. Define CNN_SCHED_TIMEOUT_EN for a DONE watchdog.
module cnn_window_sched
    import cnn_sched_pkg::*;
#(
    parameter int IMG_W       = IMG_W_DEF,
    parameter int WIN         = WIN_DEF,
    parameter int STRIDE      = 1,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                FRAME_START,
    output logic [9:0]          PIX_ADDR,
    input  logic [7:0]          PIX_RDATA,
    output logic                CNN_START,
    output logic [4:0]          CNN_X,
    output logic [4:0]          CNN_Y,
    output logic [WIN_BITS-1:0] CNN_IMGIN,
    input  logic                CNN_DONE,
    input  logic [3:0]          CNN_OUT,
    output logic                RES_VALID,
    output logic [3:0]          RES_CLASS,
    output logic [4:0]          RES_X,
    output logic [4:0]          RES_Y,
    output logic                BUSY,
    output logic                FRAME_DONE
);

    localparam int LAST_ORG = IMG_W - WIN;

    sched_state_e state_q, state_d;
    logic [4:0]   x_q, x_d, y_q, y_d;
    logic         res_valid_q, res_valid_d;
    logic         frame_done_q, frame_done_d;
    logic [3:0]   res_class_q, res_class_d;
    logic [4:0]   res_x_q, res_x_d, res_y_q, res_y_d;
    logic         fetch_start, fetch_done, timeout;
    logic [10:0]  x_adv, y_adv;

    assign x_adv = 11'(x_q) + 11'(STRIDE);
    assign y_adv = 11'(y_q) + 11'(STRIDE);

`ifdef CNN_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;

    // Counts cycles since CNN_START; the watchdog fires TIMEOUT_CYC cycles after it.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == ISSUE) begin
            wait_cnt_d = TW'(1);
        end else if (state_q == WAIT) begin
            wait_cnt_d = wait_cnt_q + TW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) wait_cnt_q <= '0;
        else     wait_cnt_q <= wait_cnt_d;
    end

    assign timeout = (state_q == WAIT) && (wait_cnt_q == TW'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        fetch_start  = 1'b0;
        res_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        res_class_d  = res_class_q;
        res_x_d      = res_x_q;
        res_y_d      = res_y_q;
        case (state_q)
            IDLE: begin
                if (FRAME_START) begin
                    state_d     = FETCH;
                    x_d         = '0;
                    y_d         = '0;
                    fetch_start = 1'b1;
                end
            end
            FETCH: if (fetch_done) state_d = ISSUE;
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (CNN_DONE) begin
                    res_class_d = CNN_OUT;
                    res_x_d     = x_q;
                    res_y_d     = y_q;
                    res_valid_d = 1'b1;
                    state_d     = NEXT;
                end else if (timeout) begin
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            NEXT: begin
                // The fetcher takes the next origin directly so it can start this edge.
                if (y_adv > 11'(LAST_ORG)) begin
                    y_d = '0;
                    if (x_adv > 11'(LAST_ORG)) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        x_d         = 5'(x_adv);
                        fetch_start = 1'b1;
                        state_d     = FETCH;
                    end
                end else begin
                    y_d         = 5'(y_adv);
                    fetch_start = 1'b1;
                    state_d     = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            res_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            res_class_q  <= '0;
            res_x_q      <= '0;
            res_y_q      <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            res_valid_q  <= res_valid_d;
            frame_done_q <= frame_done_d;
            res_class_q  <= res_class_d;
            res_x_q      <= res_x_d;
            res_y_q      <= res_y_d;
        end
    end

    cnn_win_fetch #(
        .IMG_W(IMG_W)
    ) u_fetch (
        .clk_i  (CLK),
        .rst_i  (RST),
        .start_i(fetch_start),
        .x_i    (x_d),
        .y_i    (y_d),
        .addr_o (PIX_ADDR),
        .rdata_i(PIX_RDATA),
        .done_o (fetch_done),
        .win_o  (CNN_IMGIN)
    );

    assign CNN_START  = (state_q == ISSUE);
    assign CNN_X      = x_q;
    assign CNN_Y      = y_q;
    assign BUSY       = (state_q != IDLE);
    assign RES_VALID  = res_valid_q;
    assign RES_CLASS  = res_class_q;
    assign RES_X      = res_x_q;
    assign RES_Y      = res_y_q;
    assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_cnn_window_sched.sv
// Directed bench for cnn_window_sched: one default-geometry instance and one
// STRIDE=4 instance, each with a pixel RAM model and a fixed-latency DONE model.
`timescale 1ns/1ps
module tb_cnn_window_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    // Main instance (STRIDE=1)
    logic         frame_start = 1'b0;
    logic [9:0]   pix_addr;
    logic [7:0]   pix_rdata = '0;
    logic         cnn_start;
    logic [4:0]   cnn_x, cnn_y;
    logic [199:0] cnn_imgin;
    wire          cnn_done;
    logic [3:0]   cnn_out;
    logic         res_valid;
    logic [3:0]   res_class;
    logic [4:0]   res_x, res_y;
    logic         busy, frame_done;

    // STRIDE=4 instance
    logic         frame_start4 = 1'b0;
    logic [9:0]   pix_addr4;
    logic [7:0]   pix_rdata4 = '0;
    logic         cnn_start4;
    logic [4:0]   cnn_x4, cnn_y4;
    logic [199:0] cnn_imgin4;
    wire          cnn_done4;
    logic [3:0]   cnn_out4;
    logic         res_valid4;
    logic [3:0]   res_class4;
    logic [4:0]   res_x4, res_y4;
    logic         busy4, frame_done4;

    cnn_window_sched #(.STRIDE(1), .TIMEOUT_CYC(64)) dut (
        .CLK(clk), .RST(rst), .FRAME_START(frame_start),
        .PIX_ADDR(pix_addr), .PIX_RDATA(pix_rdata),
        .CNN_START(cnn_start), .CNN_X(cnn_x), .CNN_Y(cnn_y), .CNN_IMGIN(cnn_imgin),
        .CNN_DONE(cnn_done), .CNN_OUT(cnn_out),
        .RES_VALID(res_valid), .RES_CLASS(res_class), .RES_X(res_x), .RES_Y(res_y),
        .BUSY(busy), .FRAME_DONE(frame_done)
    );

    cnn_window_sched #(.STRIDE(4)) dut4 (
        .CLK(clk), .RST(rst), .FRAME_START(frame_start4),
        .PIX_ADDR(pix_addr4), .PIX_RDATA(pix_rdata4),
        .CNN_START(cnn_start4), .CNN_X(cnn_x4), .CNN_Y(cnn_y4), .CNN_IMGIN(cnn_imgin4),
        .CNN_DONE(cnn_done4), .CNN_OUT(cnn_out4),
        .RES_VALID(res_valid4), .RES_CLASS(res_class4), .RES_X(res_x4), .RES_Y(res_y4),
        .BUSY(busy4), .FRAME_DONE(frame_done4)
    );

    // Synchronous pixel RAM: pixel value = index mod 256.
    always @(posedge clk) begin
        pix_rdata  <= pix_addr[7:0];
        pix_rdata4 <= pix_addr4[7:0];
    end

    // DONE models: one-cycle DONE 10 cycles after CNN_START, class (X+Y) mod 16.
    logic       done_en = 1'b1;
    logic       inj_done = 1'b0;
    int         m_cnt = 0, m4_cnt = 0;
    logic       m_done = 1'b0, m4_done = 1'b0;
    logic [3:0] m_out = '0, m4_out = '0;

    always @(negedge clk) begin
        m_done = 1'b0;
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0 && done_en) begin
                m_done = 1'b1;
                m_out  = 4'((int'(cnn_x) + int'(cnn_y)) % 16);
            end
        end
        if (cnn_start) m_cnt = 10;
    end

    always @(negedge clk) begin
        m4_done = 1'b0;
        if (m4_cnt > 0) begin
            m4_cnt--;
            if (m4_cnt == 0) begin
                m4_done = 1'b1;
                m4_out  = 4'((int'(cnn_x4) + int'(cnn_y4)) % 16);
            end
        end
        if (cnn_start4) m4_cnt = 10;
    end

    assign cnn_done  = m_done | inj_done;
    assign cnn_out   = m_out;
    assign cnn_done4 = m4_done;
    assign cnn_out4  = m4_out;

    // Scoreboards: expected {x, y, class} per result strobe, in scan order.
    logic [13:0] exp_q[$];
    logic [13:0] exp4_q[$];
    logic [13:0] e_main, e4;
    int          rv_cnt = 0, fd_cnt = 0, rv4_cnt = 0, fd4_cnt = 0;
    logic [13:0] last_res = '0, last_res4 = '0;

    always @(negedge clk) begin
        if (res_valid) begin
            rv_cnt++;
            checks++;
            last_res = {res_x, res_y, res_class};
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL res_unexpected: got x=%0d y=%0d class=%0d, required no result", res_x, res_y, res_class);
            end else begin
                e_main = exp_q.pop_front();
                if ({res_x, res_y, res_class} !== e_main) begin
                    failures++;
                    $display("FAIL res_main: got x=%0d y=%0d class=%0d, required x=%0d y=%0d class=%0d",
                             res_x, res_y, res_class, e_main[13:9], e_main[8:4], e_main[3:0]);
                end
            end
        end
        if (frame_done) fd_cnt++;
    end

    always @(negedge clk) begin
        if (res_valid4) begin
            rv4_cnt++;
            checks++;
            last_res4 = {res_x4, res_y4, res_class4};
            if (exp4_q.size() == 0) begin
                failures++;
                $display("FAIL res4_unexpected: got x=%0d y=%0d class=%0d, required no result", res_x4, res_y4, res_class4);
            end else begin
                e4 = exp4_q.pop_front();
                if ({res_x4, res_y4, res_class4} !== e4) begin
                    failures++;
                    $display("FAIL res_s4: got x=%0d y=%0d class=%0d, required x=%0d y=%0d class=%0d",
                             res_x4, res_y4, res_class4, e4[13:9], e4[8:4], e4[3:0]);
                end
            end
        end
        if (frame_done4) fd4_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic fill_exp(input int stride, input int count, input bit s4);
        int n = 0;
        for (int x = 0; x <= 23; x += stride) begin
            for (int y = 0; y <= 23; y += stride) begin
                if (n < count) begin
                    if (s4) exp4_q.push_back({5'(x), 5'(y), 4'((x + y) % 16)});
                    else    exp_q.push_back({5'(x), 5'(y), 4'((x + y) % 16)});
                end
                n++;
            end
        end
    endtask

    // Leaves the caller at the mid-point of the first cycle after FRAME_START was sampled.
    task automatic pulse_start(input bit s4);
        @(negedge clk);
        if (s4) frame_start4 = 1'b1; else frame_start = 1'b1;
        @(negedge clk);
        frame_start  = 1'b0;
        frame_start4 = 1'b0;
    endtask

    task automatic wait_frame_done(input string name, input bit s4, input int limit);
        int n = 0;
        while (((s4 ? fd4_cnt : fd_cnt) == 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n < limit), 32'd1);
    endtask

    typedef struct {
        int         cyc;
        logic       chk_addr;
        logic [9:0] addr;
        logic       busy;
        logic       start;
    } fetch_vec_t;

    typedef struct {
        int         idx;
        logic [7:0] val;
    } byte_vec_t;

    fetch_vec_t fv[10];
    byte_vec_t  bv[7];

    initial begin
        #3ms;
        $display("FAIL global_timeout: got no finish, required finish within 3ms");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n, starts, rv0, fd0;
        int cyc;

        fv[0] = '{1,  1'b1, 10'd0,   1'b1, 1'b0};
        fv[1] = '{2,  1'b1, 10'd1,   1'b1, 1'b0};
        fv[2] = '{5,  1'b1, 10'd4,   1'b1, 1'b0};
        fv[3] = '{6,  1'b1, 10'd28,  1'b1, 1'b0};
        fv[4] = '{13, 1'b1, 10'd58,  1'b1, 1'b0};
        fv[5] = '{21, 1'b1, 10'd112, 1'b1, 1'b0};
        fv[6] = '{25, 1'b1, 10'd116, 1'b1, 1'b0};
        fv[7] = '{26, 1'b0, 10'd0,   1'b1, 1'b0};
        fv[8] = '{27, 1'b0, 10'd0,   1'b1, 1'b1};
        fv[9] = '{28, 1'b0, 10'd0,   1'b1, 1'b0};

        bv[0] = '{0,  8'h00};
        bv[1] = '{1,  8'h01};
        bv[2] = '{4,  8'h04};
        bv[3] = '{5,  8'h1C};
        bv[4] = '{12, 8'h3A};
        bv[5] = '{20, 8'h70};
        bv[6] = '{24, 8'h74};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pix_addr", 32'(pix_addr), 32'd0);
        check("rst_cnn_start", 32'(cnn_start), 32'd0);
        check("rst_imgin_zero", 32'(cnn_imgin == '0), 32'd1);
        check("rst_res", {res_valid, res_class, res_x, res_y, frame_done}, 32'd0);
        rst = 1'b0;

        // First window of a full frame: address walk, start timing, packed bytes
        fill_exp(1, 576, 1'b0);
        pulse_start(1'b0);
        for (int k = 1; k <= 28; k++) begin
            foreach (fv[i]) begin
                if (fv[i].cyc == k) begin
                    if (fv[i].chk_addr) check($sformatf("fetch_addr_c%0d", k), 32'(pix_addr), 32'(fv[i].addr));
                    check($sformatf("fetch_busy_c%0d", k), 32'(busy), 32'(fv[i].busy));
                    check($sformatf("fetch_start_c%0d", k), 32'(cnn_start), 32'(fv[i].start));
                end
            end
            if (k == 27) begin
                foreach (bv[i]) check($sformatf("imgin_byte%0d", bv[i].idx), 32'(cnn_imgin[bv[i].idx*8 +: 8]), 32'(bv[i].val));
                check("w0_origin", {cnn_x, cnn_y}, 32'd0);
            end
            @(negedge clk);
        end

        // DONE pulses during FETCH and FRAME_START while busy must be ignored
        n = 0;
        while (!res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("w0_res_seen", 32'(res_valid), 32'd1);
        inj_done    = 1'b1;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        rv0 = rv_cnt;
        check("w1_addr0", 32'(pix_addr), 32'd1);
        @(negedge clk);
        check("w1_addr1", 32'(pix_addr), 32'd2);
        @(negedge clk);
        check("w1_addr2", 32'(pix_addr), 32'd3);
        @(negedge clk);
        inj_done = 1'b0;
        repeat (8) @(negedge clk);
        check("inj_no_extra_res", 32'(rv_cnt), 32'(rv0));
        check("inj_still_busy", 32'(busy), 32'd1);

        // Rest of the frame
        wait_frame_done("frame_done_seen", 1'b0, 30000);
        repeat (5) @(negedge clk);
        check("frame_res_count", 32'(rv_cnt), 32'd576);
        check("frame_done_count", 32'(fd_cnt), 32'd1);
        check("frame_last_res", 32'(last_res), {18'd0, 5'd23, 5'd23, 4'd14});
        check("frame_exp_empty", 32'(exp_q.size()), 32'd0);
        check("frame_idle", 32'(busy), 32'd0);

        // STRIDE=4 frame
        fill_exp(4, 36, 1'b1);
        pulse_start(1'b1);
        wait_frame_done("s4_done_seen", 1'b1, 5000);
        repeat (5) @(negedge clk);
        check("s4_res_count", 32'(rv4_cnt), 32'd36);
        check("s4_done_count", 32'(fd4_cnt), 32'd1);
        check("s4_last_res", 32'(last_res4), {18'd0, 5'd20, 5'd20, 4'd8});
        check("s4_exp_empty", 32'(exp4_q.size()), 32'd0);

        // Reset while waiting on window 5
        fill_exp(1, 4, 1'b0);
        rv0 = rv_cnt;
        fd0 = fd_cnt;
        pulse_start(1'b0);
        starts = 0;
        n = 0;
        while (starts < 5 && n < 1000) begin
            if (cnn_start) starts++;
            if (starts < 5) begin
                @(negedge clk);
                n++;
            end
        end
        check("rstw_reached_w5", 32'(starts), 32'd5);
        check("rstw_w5_origin", {cnn_x, cnn_y}, {22'd0, 5'd0, 5'd4});
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstw_busy", 32'(busy), 32'd0);
        check("rstw_origin", {cnn_x, cnn_y}, 32'd0);
        check("rstw_addr", 32'(pix_addr), 32'd0);
        check("rstw_imgin_zero", 32'(cnn_imgin == '0), 32'd1);
        check("rstw_res", {res_valid, res_class, res_x, res_y, frame_done, cnn_start}, 32'd0);
        check("rstw_res_count", 32'(rv_cnt - rv0), 32'd4);
        repeat (20) @(negedge clk);
        check("rstw_quiet_res", 32'(rv_cnt - rv0), 32'd4);
        check("rstw_quiet_fd", 32'(fd_cnt), 32'(fd0));
        check("rstw_quiet_busy", 32'(busy), 32'd0);

        // Fresh frame after reset begins again at origin (0,0)
        fill_exp(1, 2, 1'b0);
        pulse_start(1'b0);
        check("restart_addr", 32'(pix_addr), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        n = 0;
        while (!cnn_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("restart_start_cyc", 32'(n), 32'd26);
        check("restart_origin", {cnn_x, cnn_y}, 32'd0);
        n = 0;
        while ((rv_cnt - rv0) < 6 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("restart_two_res", 32'(rv_cnt - rv0), 32'd6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("restart_exp_empty", 32'(exp_q.size()), 32'd0);

`ifdef CNN_SCHED_TIMEOUT_EN
        // Watchdog: DONE never arrives
        done_en = 1'b0;
        rv0 = rv_cnt;
        fd0 = fd_cnt;
        repeat (15) @(negedge clk);
        pulse_start(1'b0);
        n = 0;
        while (!cnn_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("to_start_seen", 32'(cnn_start), 32'd1);
        cyc = 0;
        while (!frame_done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("to_done_latency", 32'(cyc), 32'd64);
        check("to_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("to_fd_count", 32'(fd_cnt - fd0), 32'd1);
        check("to_no_res", 32'(rv_cnt - rv0), 32'd0);
        done_en = 1'b1;
`else
        cyc = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
